// File: rtl/pc_fetch_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : pc_fetch_ctrl                                                |
// | Description : Architectural PC register and instruction-fetch sequencer.   |
// |               Drives the imem request handshake, selects the next PC from  |
// |               sequential/branch/jump sources, counts retired instructions  |
// |               and flags misaligned redirect targets.                       |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module pc_fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] pc_out,
  input  logic [31:0] pc_inc,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  input  logic        jump,
  input  logic [31:0] jump_target,
  input  logic        stall,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  output logic        if_valid,
  output logic [31:0] retire_cnt,
  output logic        addr_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [31:0] r_pc;
  logic [31:0] r_retire_cnt;
  logic        r_addr_err;
  logic        w_advance;
  logic        w_redirect;
  logic        w_misaligned;
  logic [31:0] w_target;
  logic [31:0] w_pc_nxt;

  // Jump outranks branch; every PC source is forced to a word boundary.
  assign w_redirect   = jump | br_taken;
  assign w_target     = jump ? jump_target : br_target;
  assign w_misaligned = w_redirect & (|w_target[1:0]);
  assign w_pc_nxt     = w_redirect ? {w_target[31:2], 2'b00}
                                   : {pc_inc[31:2], 2'b00};

  always_comb begin
    w_state_nxt = r_state;
    imem_req    = 1'b0;
    if_valid    = 1'b0;
    w_advance   = 1'b0;
    case (r_state)
      IDLE: begin
        w_state_nxt = REQ;
      end
      REQ: begin
        imem_req = 1'b1;
        if_valid = imem_ack;
        if (imem_ack) begin
          if (stall) begin
            w_state_nxt = HOLD;
          end else begin
            w_advance = 1'b1;
          end
        end
      end
      HOLD: begin
        if_valid = 1'b1;
        if (!stall) begin
          w_advance   = 1'b1;
          w_state_nxt = REQ;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Redirect inputs only matter on the advance edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc         <= RESET_PC;
      r_retire_cnt <= 32'd0;
      r_addr_err   <= 1'b0;
    end else if (w_advance) begin
      r_pc         <= w_pc_nxt;
      r_retire_cnt <= r_retire_cnt + 32'd1;
      if (w_misaligned) begin
        r_addr_err <= 1'b1;
      end
    end
  end

  assign pc_out     = r_pc;
  assign imem_addr  = r_pc;
  assign retire_cnt = r_retire_cnt;
  assign addr_err   = r_addr_err;

endmodule
`default_nettype wire

// File: tb/tb_pc_fetch_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_pc_fetch_ctrl                                             |
// | Description : Scoreboard bench for pc_fetch_ctrl with a transaction-level  |
// |               reference model and randomized fetch/stall/redirect traffic. |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_pc_fetch_ctrl;

  localparam logic [31:0] C_RESET_PC = 32'h0000_0000;

  logic        clk;
  logic        rst_n;
  logic [31:0] pc_out;
  logic [31:0] pc_inc;
  logic        br_taken;
  logic [31:0] br_target;
  logic        jump;
  logic [31:0] jump_target;
  logic        stall;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic        if_valid;
  logic [31:0] retire_cnt;
  logic        addr_err;
  logic [1:0]  inc_noise;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic        req;
    logic        valid;
    logic [31:0] pc;
    logic [31:0] cnt;
    logic        err;
  } exp_t;

  exp_t exp_q[$];

  // Reference model: program-order view of the fetch stream.
  bit          m_first;
  bit          m_held;
  logic [31:0] m_pc;
  logic [31:0] m_cnt;
  bit          m_err;

  pc_fetch_ctrl #(.RESET_PC(C_RESET_PC)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .pc_out      (pc_out),
    .pc_inc      (pc_inc),
    .br_taken    (br_taken),
    .br_target   (br_target),
    .jump        (jump),
    .jump_target (jump_target),
    .stall       (stall),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .if_valid    (if_valid),
    .retire_cnt  (retire_cnt),
    .addr_err    (addr_err)
  );

  // External incrementer, with junk low bits the DUT must discard.
  assign pc_inc = pc_out + 32'd4 + {30'd0, inc_noise};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_first = 1'b1;
    m_held  = 1'b0;
    m_pc    = C_RESET_PC;
    m_cnt   = 32'd0;
    m_err   = 1'b0;
  endtask

  // Predict this cycle's outputs from the current inputs, then advance the model.
  task automatic issue();
    exp_t e;
    bit   adv;
    logic [31:0] tgt;
    adv     = 1'b0;
    e.pc    = m_pc;
    e.cnt   = m_cnt;
    e.err   = m_err;
    if (m_first) begin
      e.req   = 1'b0;
      e.valid = 1'b0;
      m_first = 1'b0;
    end else if (m_held) begin
      e.req   = 1'b0;
      e.valid = 1'b1;
      adv     = !stall;
      m_held  = stall;
    end else begin
      e.req   = 1'b1;
      e.valid = imem_ack;
      adv     = imem_ack && !stall;
      m_held  = imem_ack && stall;
    end
    exp_q.push_back(e);
    if (adv) begin
      if (jump || br_taken) begin
        tgt = jump ? jump_target : br_target;
        if (tgt % 4 != 0) m_err = 1'b1;
        m_pc = tgt - (tgt % 4);
      end else begin
        m_pc = m_pc + 32'd4;
      end
      m_cnt = m_cnt + 32'd1;
    end
  endtask

  task automatic step(input bit ack, input bit stl, input bit jmp, input logic [31:0] jt,
                      input bit br, input logic [31:0] bt);
    @(posedge clk);
    #1;
    imem_ack    = ack;
    stall       = stl;
    jump        = jmp;
    jump_target = jt;
    br_taken    = br;
    br_target   = bt;
    inc_noise   = 2'($urandom_range(0, 3));
    issue();
  endtask

  task automatic check_reset_values();
    chk("rst_req", {31'd0, imem_req}, 32'd0);
    chk("rst_valid", {31'd0, if_valid}, 32'd0);
    chk("rst_pc", pc_out, C_RESET_PC);
    chk("rst_addr", imem_addr, C_RESET_PC);
    chk("rst_cnt", retire_cnt, 32'd0);
    chk("rst_err", {31'd0, addr_err}, 32'd0);
  endtask

  // Monitor: one expectation is consumed per cycle the model produced one.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("imem_req", {31'd0, imem_req}, {31'd0, e.req});
        chk("if_valid", {31'd0, if_valid}, {31'd0, e.valid});
        chk("pc_out", pc_out, e.pc);
        chk("imem_addr", imem_addr, e.pc);
        chk("retire_cnt", retire_cnt, e.cnt);
        chk("addr_err", {31'd0, addr_err}, {31'd0, e.err});
      end
    end
  end

  initial begin
    rst_n       = 1'b0;
    imem_ack    = 1'b0;
    stall       = 1'b0;
    jump        = 1'b0;
    jump_target = 32'd0;
    br_taken    = 1'b0;
    br_target   = 32'd0;
    inc_noise   = 2'd0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_reset_values();
    imem_ack = 1'b1;
    rst_n    = 1'b1;
    issue();

    // Free-running sequential fetch.
    repeat (4) step(1, 0, 0, 0, 0, 0);
    // Stall arriving with ack, held for 3 cycles.
    step(1, 1, 0, 0, 0, 0);
    repeat (3) step(0, 1, 1, 32'h900, 1, 32'h904);
    step(0, 0, 0, 0, 0, 0);
    // Jump beats branch; branch alone.
    step(1, 0, 1, 32'h400, 1, 32'h100);
    step(1, 0, 0, 0, 1, 32'h100);
    step(0, 0, 1, 32'h40, 0, 0);
    // Redirects ignored without ack.
    step(0, 1, 1, 32'h40, 1, 32'h44);
    // Misaligned redirect, then aligned one: flag stays sticky.
    step(1, 0, 0, 0, 1, 32'h203);
    step(1, 0, 1, 32'h300, 0, 0);
    repeat (2) step(1, 0, 0, 0, 0, 0);

    // Ack withheld, reset pulsed mid-wait.
    repeat (5) step(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_values();
    @(posedge clk);
    #1;
    imem_ack = 1'b0;
    rst_n    = 1'b1;
    model_reset();
    issue();
    repeat (3) step(1, 0, 0, 0, 0, 0);

    // Count wrap.
    @(posedge clk);
    #1;
    force dut.r_retire_cnt = 32'hFFFF_FFFE;
    #1;
    release dut.r_retire_cnt;
    m_cnt     = 32'hFFFF_FFFE;
    imem_ack  = 1'b1;
    stall     = 1'b0;
    jump      = 1'b0;
    br_taken  = 1'b0;
    issue();
    repeat (3) step(1, 0, 0, 0, 0, 0);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      logic [31:0] jt;
      logic [31:0] bt;
      jt = $urandom();
      bt = $urandom();
      if ($urandom_range(0, 15) != 0) jt[1:0] = 2'b00;
      if ($urandom_range(0, 15) != 0) bt[1:0] = 2'b00;
      step($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 3,
           $urandom_range(0, 3) == 0, jt, $urandom_range(0, 3) == 0, bt);
    end

    @(negedge clk);
    #1;
    chk("queue_drained", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pc_fetch_ctrl.md
# pc_fetch_ctrl

Program-counter register and fetch sequencer for the MIPS core. It holds the architectural PC, drives the instruction-memory request handshake, and selects the next PC from the sequential value, a taken branch or a jump. Its `pc_out` feeds the PC incrementer, and the incrementer's PC+4 result returns here as `pc_inc`. It also keeps a retired-instruction count and a sticky misaligned-target flag.

## Interface
- `RESET_PC`, 32'h0000_0000, PC value loaded on reset (word aligned).
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `pc_out`  out  32  current PC; drives the PC incrementer input.
- `pc_inc`  in  32  PC+4 returned from the incrementer.
- `br_taken`  in  1  branch taken for the instruction currently valid.
- `br_target`  in  32  branch target address.
- `jump`  in  1  jump (J/JAL/JR) for the instruction currently valid.
- `jump_target`  in  32  jump target address, already formed.
- `stall`  in  1  downstream cannot accept the current instruction.
- `imem_req`  out  1  fetch request for address `imem_addr`.
- `imem_addr`  out  32  fetch address; always equal to `pc_out`.
- `imem_ack`  in  1  instruction memory returns the word at `imem_addr` this cycle.
- `if_valid`  out  1  the instruction at `pc_out` is present this cycle.
- `retire_cnt`  out  32  count of PC advances; wraps modulo 2^32.
- `addr_err`  out  1  sticky flag: a misaligned redirect target was seen.

## Operation
- States: IDLE, REQ, HOLD.
- IDLE is entered only by reset. It lasts exactly one cycle with `imem_req`=0, then moves to REQ.
- REQ:
  - `imem_req`=1.
  - `if_valid` = `imem_ack`, combinational.
  - On ack with `stall`=0: the PC advances and the state stays REQ, so back-to-back requests run at 1 instruction per cycle.
  - On ack with `stall`=1: the PC is held and the state goes to HOLD.
  - No ack: wait in REQ, PC unchanged.
- HOLD:
  - `imem_req`=0 and `if_valid`=1.
  - When `stall`=0, the PC advances and the state goes to REQ. Otherwise the block stays in HOLD.
- Next-PC priority:
  1. `jump` → `jump_target`.
  2. else `br_taken` → `br_target`.
  3. else `pc_inc`.
- Redirect inputs are sampled only on the advance edge. They are ignored at all other times.
- Misaligned target: if the selected redirect target has bits [1:0] ≠ 0, the PC loads the target with bits [1:0] forced to 00 and `addr_err` is set. `addr_err` is cleared only by reset.
- `pc_inc` is used unchecked; its low bits are forced to 00 as well, without flagging.
- `retire_cnt` increments by 1 on every advance edge, wrapping from 32'hFFFF_FFFF to 0.
- `imem_ack` is ignored in IDLE and HOLD.

## Timing
- Reset values: `pc_out`=`RESET_PC`, `imem_addr`=`RESET_PC`, `imem_req`=0, `if_valid`=0, `retire_cnt`=0, `addr_err`=0, state=IDLE.
- The first request is asserted in the 2nd cycle after `rst_n` deasserts.
- Fetch latency: `if_valid` is high in the same cycle as `imem_ack`.
- The new PC is visible on `pc_out`/`imem_addr` one cycle after the advance edge.
- Throughput: 1 instruction per cycle when `imem_ack` is held high and `stall`=0.
- Stall arriving with ack: the instruction is held with `if_valid` high for every cycle `stall` is high. The PC advances on the first edge where `stall`=0. No refetch.
- Stall with no ack in REQ has no effect.
- `jump` and `br_taken` high together: the jump wins.
- Reset mid-fetch: all state returns to reset values immediately, regardless of the clock. Any outstanding request is abandoned. The memory must tolerate a dropped request.

## Test plan
- Reset release, `imem_ack` tied 1, no redirects → `imem_req` rises in cycle 2. `pc_out` steps 0, 4, 8, 12. `retire_cnt`=3 after the third advance.
- Ack in cycle N with `stall` high for 3 cycles → PC stays 0x8 and `if_valid` stays high for 4 cycles. PC becomes 0xC on the following edge.
- Same cycle: `br_taken`=1 with `br_target`=0x100, `jump`=1 with `jump_target`=0x400 → next `pc_out`=0x400. With only the branch → 0x100.
- Redirect to 0x203 → `pc_out`=0x200 and `addr_err`=1. A later aligned redirect leaves `addr_err`=1 until reset.
- Ack withheld 5 cycles, then `rst_n` pulsed low mid-wait → outputs return to reset values asynchronously, then 1 IDLE cycle, then the request at `RESET_PC`.
- `retire_cnt` preloaded near 32'hFFFF_FFFF via long run (or force) → wraps to 0 on the next advance.
